restoring_div32: RTL and testbench

- Sequential 32-bit restoring divider; produces one quotient bit per clock.
- Sits directly upstream of the 32-bit ripple subtractor sub32. Each cycle it forms the shifted partial remainder and divisor operands for sub32, then consumes diff/carry to decide quotient bit and restore.
- Used as the multi-cycle divide unit beside the lab ALU.

---
 rtl/restoring_div32_pkg.sv | 22 ++
 rtl/restoring_div32_sub32.sv | 14 +
 rtl/restoring_div32.sv | 124 ++++++++++++
 tb/tb_restoring_div32.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_div32_pkg.sv
// Shared definitions for the 32-bit restoring divider: state encodings,
// iteration bound and the divide-by-zero quotient.
package restoring_div32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(31);
    localparam logic [WIDTH-1:0] DBZ_QUOT  = 32'hFFFF_FFFF;

    // Magnitude of a two's complement value; 0x80000000 maps to itself.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/restoring_div32_sub32.sv
// 32-bit subtractor: diff = a - b computed as a + ~b + c_in; carry=1 means no borrow.
module sub32
    import restoring_div32_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             carry_o
);

    assign {carry_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(c_in_i);

endmodule

// File: rtl/restoring_div32.sv
// Sequential restoring divider, one quotient bit per clock via sub32.
// Define DIV_SIGNED_EN for two's complement (truncating) division.
module restoring_div32
    import restoring_div32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] r_sh, diff, rem_d, quo_d;
    logic [WIDTH-1:0] quot_res, rem_res, dvd_cap, dvs_cap;
    logic             carry, take;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign r_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

    sub32 u_sub32 (
        .a_i     (r_sh),
        .b_i     (dvs_q),
        .c_in_i  (1'b1),
        .diff_o  (diff),
        .carry_o (carry)
    );

    // The bit shifted out of R makes the 33-bit trial value exceed any divisor.
    assign take  = rem_q[WIDTH-1] | carry;
    assign rem_d = take ? diff : r_sh;
    assign quo_d = {quo_q[WIDTH-2:0], take};

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_r_q;

    assign dvd_cap  = abs_val(dividend);
    assign dvs_cap  = abs_val(divisor);
    assign quot_res = neg_q_q ? WIDTH'(-quo_d) : quo_d;
    assign rem_res  = neg_r_q ? WIDTH'(-rem_d) : rem_d;
`else
    assign dvd_cap  = dividend;
    assign dvs_cap  = divisor;
    assign quot_res = quo_d;
    assign rem_res  = rem_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == ITER_LAST) begin
                        state_q     <= ST_FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quot_res;
                        remainder_q <= rem_res;
                    end
                end
                default: begin
                    // IDLE and FIN both accept a new request.
                    state_q <= ST_IDLE;
                    if (start) begin
                        dbz_q <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= ST_FIN;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= DBZ_QUOT;
                            remainder_q <= dividend;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            rem_q   <= '0;
                            quo_q   <= dvd_cap;
                            dvs_q   <= dvs_cap;
                            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r_q <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div32.sv
// Self-checking bench for restoring_div32 against an arithmetic reference model.
module tb_restoring_div32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    restoring_div32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference results straight from the arithmetic definition of division.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        z = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end
`ifdef DIV_SIGNED_EN
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Called at a negedge; returns at the negedge where done is first seen.
    // lat counts rising edges from the start edge up to done (start edge included).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = 1;
        bcyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0)
            $display("FAIL reset_values: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic();
        int lat, bcyc;
        run_op(32'd100, 32'd7, lat, bcyc);
        n_checks++;
        if (lat !== 33) $display("FAIL basic_latency: got %0d edges, want 33", lat);
        else n_pass++;
        n_checks++;
        if (bcyc !== 32) $display("FAIL basic_busy_cycles: got %0d, want 32", bcyc);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL basic_100_div_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || quotient !== 32'd14)
            $display("FAIL done_pulse_hold: got done=%b q=%0d, want done=0 q=14", done, quotient);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        run_op(32'hFFFF_FFFF, 32'd1, lat, bcyc);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFF, 32'd0})
            $display("FAIL b2b_first: got q=%h r=%h, want q=ffffffff r=0", quotient, remainder);
        else n_pass++;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
        n_checks++;
        if (lat !== 33 || {quotient, remainder} !== {32'd1, 32'd0})
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=33 q=1 r=0",
                     lat, quotient, remainder);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        run_op(32'd1234, 32'd0, lat, bcyc);
        n_checks++;
        if (lat !== 1 || bcyc !== 0)
            $display("FAIL dbz_latency: got lat=%0d busy_cycles=%0d, want lat=1 busy_cycles=0",
                     lat, bcyc);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'd1234, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, want q=ffffffff r=1234 dbz=1",
                     quotient, remainder, div_by_zero);
        else n_pass++;
        run_op(32'd8, 32'd2, lat, bcyc);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'd4, 32'd0, 1'b0})
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b, want q=4 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int lat;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (9) begin @(negedge clk); lat++; end
        start = 1'b1; dividend = 32'd77; divisor = 32'd0;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat !== 33 || {quotient, remainder, div_by_zero} !== {32'd333, 32'd1, 1'b0})
            $display("FAIL start_ignored: got lat=%0d q=%0d r=%0d dbz=%b, want lat=33 q=333 r=1 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bcyc, seen;
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0)
            $display("FAIL async_reset: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL reset_no_done: got %0d active cycles, want 0", seen);
        else n_pass++;
        run_op(32'd50, 32'd5, lat, bcyc);
        n_checks++;
        if (lat !== 33 || {quotient, remainder} !== {32'd10, 32'd0})
            $display("FAIL after_reset_50_div_5: got lat=%0d q=%0d r=%0d, want lat=33 q=10 r=0",
                     lat, quotient, remainder);
        else n_pass++;
        @(negedge clk);
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat, bcyc;
        run_op(32'hFFFF_FFF9, 32'd2, lat, bcyc);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF})
            $display("FAIL signed_m7_div_2: got q=%h r=%h, want q=fffffffd r=ffffffff",
                     quotient, remainder);
        else n_pass++;
        run_op(32'd7, 32'hFFFF_FFFE, lat, bcyc);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'd1})
            $display("FAIL signed_7_div_m2: got q=%h r=%h, want q=fffffffd r=1",
                     quotient, remainder);
        else n_pass++;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
        n_checks++;
        if (lat !== 33 || {quotient, remainder} !== {32'h8000_0000, 32'd0})
            $display("FAIL signed_min_div_m1: got lat=%0d q=%h r=%h, want lat=33 q=80000000 r=0",
                     lat, quotient, remainder);
        else n_pass++;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int lat, bcyc;
        logic [31:0] a, b, eq, er;
        logic ez;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = a >> $urandom_range(0, 31);
                3:       b = (i % 3 == 0) ? 32'd0 : 32'h8000_0000 | $urandom;
                default: b = $urandom & 32'h0000_FFFF;
            endcase
            model(a, b, eq, er, ez);
            run_op(a, b, lat, bcyc);
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== {eq, er, ez} || lat !== (ez ? 1 : 33))
                $display("FAIL random_%0d: a=%h b=%h got q=%h r=%h dbz=%b lat=%0d, want q=%h r=%h dbz=%b lat=%0d",
                         i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, ez ? 1 : 33);
            else n_pass++;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
